mu0_loader: RTL and testbench



---
 rtl/mu0_pkg.sv | 18 +
 rtl/mu0_mem_mux.sv | 33 +++
 rtl/mu0_loader.sv | 173 +++++++++++++++++
 tb/tb_mu0_loader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mu0_pkg.sv
// rtl/mu0_pkg.sv - shared widths and loader state encoding for the MU0 boot loader
package mu0_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA_HI,
        DATA_LO,
        CSUM_HI,
        CSUM_LO,
        RUN,
        ERROR
    } state_t;

endpackage

// File: rtl/mu0_mem_mux.sv
// rtl/mu0_mem_mux.sv - selects loader write port or processor memory signals onto the memory port
module mu0_mem_mux #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              sel_cpu,
    input  logic [ADDR_W-1:0] ld_address,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_write,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_data_out,
    input  logic              cpu_memory_read,
    input  logic              cpu_memory_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_read,
    output logic              mem_write
);

    always_comb begin
        mem_address = ld_address;
        mem_data    = ld_data;
        mem_read    = 1'b0;
        mem_write   = ld_write;
        if (sel_cpu) begin
            mem_address = cpu_address;
            mem_data    = cpu_data_out;
            mem_read    = cpu_memory_read;
            mem_write   = cpu_memory_write;
        end
    end

endmodule

// File: rtl/mu0_loader.sv
// rtl/mu0_loader.sv - length-prefixed boot image loader for MU0 memory; MU0_LOADER_CHECKSUM_EN adds a trailing sum check
module mu0_loader
    import mu0_pkg::*;
#(
    parameter int                ADDR_W    = mu0_pkg::ADDR_W,
    parameter int                DATA_W    = mu0_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              cpu_rst,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_data_out,
    input  logic              cpu_memory_read,
    input  logic              cpu_memory_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_read,
    output logic              mem_write,
    output logic              done,
    output logic              error
);

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    state_t            state;
    logic [15:0]       word_total;
    logic [15:0]       word_cnt;
    logic [7:0]        hi_byte;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W-1:0] ld_address;
    logic [DATA_W-1:0] ld_data;
    logic              ld_write;
    logic              accept;
    logic [15:0]       rx_word;
    logic              last_word;
`ifdef MU0_LOADER_CHECKSUM_EN
    logic [15:0]       csum;
`endif

    assign accept    = rx_valid && rx_ready;
    assign rx_word   = {hi_byte, rx_data};
    assign last_word = (word_cnt + 16'd1) == word_total;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HDR_HI;
            word_total <= '0;
            word_cnt   <= '0;
            hi_byte    <= '0;
            addr_cnt   <= BASE_ADDR;
            ld_address <= BASE_ADDR;
            ld_data    <= '0;
            ld_write   <= 1'b0;
            cpu_rst    <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            rx_ready   <= 1'b0;
`ifdef MU0_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            ld_write <= 1'b0;
            rx_ready <= 1'b1;
            case (state)
                HDR_HI: if (accept) begin
                    hi_byte <= rx_data;
                    state   <= HDR_LO;
                end
                HDR_LO: if (accept) begin
                    word_total <= rx_word;
                    word_cnt   <= '0;
                    addr_cnt   <= BASE_ADDR;
                    if (rx_word == 16'd0) begin
`ifdef MU0_LOADER_CHECKSUM_EN
                        state    <= CSUM_HI;
`else
                        state    <= RUN;
                        rx_ready <= 1'b0;
                        done     <= 1'b1;
                        cpu_rst  <= 1'b0;
`endif
                    end else if ({1'b0, rx_word} > MAX_WORDS) begin
                        state    <= ERROR;
                        rx_ready <= 1'b0;
                        error    <= 1'b1;
                    end else begin
                        state <= DATA_HI;
                    end
                end
                DATA_HI: if (accept) begin
                    hi_byte <= rx_data;
                    state   <= DATA_LO;
                end
                DATA_LO: if (accept) begin
                    ld_address <= addr_cnt;
                    ld_data    <= rx_word;
                    ld_write   <= 1'b1;
                    addr_cnt   <= addr_cnt + 1'b1;
                    word_cnt   <= word_cnt + 16'd1;
`ifdef MU0_LOADER_CHECKSUM_EN
                    csum       <= csum + rx_word;
`endif
                    if (last_word) begin
`ifdef MU0_LOADER_CHECKSUM_EN
                        state    <= CSUM_HI;
`else
                        // done follows one edge later so the final write pulse is never shared with the CPU
                        state    <= RUN;
                        rx_ready <= 1'b0;
`endif
                    end else begin
                        state <= DATA_HI;
                    end
                end
`ifdef MU0_LOADER_CHECKSUM_EN
                CSUM_HI: if (accept) begin
                    hi_byte <= rx_data;
                    state   <= CSUM_LO;
                end
                CSUM_LO: if (accept) begin
                    rx_ready <= 1'b0;
                    if (rx_word == csum) begin
                        state   <= RUN;
                        done    <= 1'b1;
                        cpu_rst <= 1'b0;
                    end else begin
                        state <= ERROR;
                        error <= 1'b1;
                    end
                end
`endif
                RUN: begin
                    rx_ready <= 1'b0;
                    done     <= 1'b1;
                    cpu_rst  <= 1'b0;
                end
                ERROR: begin
                    rx_ready <= 1'b0;
                    error    <= 1'b1;
                    cpu_rst  <= 1'b1;
                end
                default: begin
                    state    <= ERROR;
                    rx_ready <= 1'b0;
                    error    <= 1'b1;
                end
            endcase
        end
    end

    mu0_mem_mux #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_mem_mux (
        .sel_cpu         (done),
        .ld_address      (ld_address),
        .ld_data         (ld_data),
        .ld_write        (ld_write),
        .cpu_address     (cpu_address),
        .cpu_data_out    (cpu_data_out),
        .cpu_memory_read (cpu_memory_read),
        .cpu_memory_write(cpu_memory_write),
        .mem_address     (mem_address),
        .mem_data        (mem_data),
        .mem_read        (mem_read),
        .mem_write       (mem_write)
    );

endmodule

// File: tb/tb_mu0_loader.sv
// tb/tb_mu0_loader.sv - directed self-checking bench for mu0_loader
module tb_mu0_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        cpu_rst;
    logic [11:0] cpu_address;
    logic [15:0] cpu_data_out;
    logic        cpu_memory_read;
    logic        cpu_memory_write;
    logic [11:0] mem_address;
    logic [15:0] mem_data;
    logic        mem_read;
    logic        mem_write;
    logic        done;
    logic        error;

    int checks   = 0;
    int failures = 0;

    mu0_loader dut (
        .clk             (clk),
        .rst             (rst),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .cpu_rst         (cpu_rst),
        .cpu_address     (cpu_address),
        .cpu_data_out    (cpu_data_out),
        .cpu_memory_read (cpu_memory_read),
        .cpu_memory_write(cpu_memory_write),
        .mem_address     (mem_address),
        .mem_data        (mem_data),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .done            (done),
        .error           (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (rx_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (rx_ready === 1'b1) else begin
            failures++;
            $error("FAIL send_timeout observed=%h expected=1", rx_ready);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_rx_ready", rx_ready, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rx_data = '0; rx_valid = 1'b0;
        cpu_address = '0; cpu_data_out = '0; cpu_memory_read = 1'b1; cpu_memory_write = 1'b0;
        tick(); tick();
        chk("reset_cpu_rst", cpu_rst, 1);
        chk("reset_done", done, 0);
        chk("reset_error", error, 0);
        chk("reset_mem_write", mem_write, 0);
        chk("reset_mem_read", mem_read, 0);
        chk("reset_rx_ready", rx_ready, 0);
        @(negedge clk);
        rst = 1'b0; cpu_memory_read = 1'b0;
        cpu_memory_write = 1'b1; cpu_address = 12'hFFF; cpu_data_out = 16'hDEAD;
        tick();
        chk("ready_after_reset", rx_ready, 1);

        // three-word image: CPU signals driven but must be ignored while loading
        send(8'h00); send(8'h03);
        chk("hdr_no_write", mem_write, 0);
        send(8'h10); send(8'h05);
        chk("w0_write", mem_write, 1);
        chk("w0_addr", mem_address, 12'h000);
        chk("w0_data", mem_data, 16'h1005);
        chk("w0_done", done, 0);
        send(8'h30);
        chk("gap_write", mem_write, 0);
        send(8'h06);
        chk("w1_write", mem_write, 1);
        chk("w1_addr", mem_address, 12'h001);
        chk("w1_data", mem_data, 16'h3006);
        send(8'h70); send(8'h00);
        chk("w2_write", mem_write, 1);
        chk("w2_addr", mem_address, 12'h002);
        chk("w2_data", mem_data, 16'h7000);
        chk("w2_done", done, 0);
        chk("w2_cpu_rst", cpu_rst, 1);
        cpu_memory_write = 1'b0; cpu_address = '0; cpu_data_out = '0;
`ifdef MU0_LOADER_CHECKSUM_EN
        send(8'hB0);
        chk("csum_gap_write", mem_write, 0);
        send(8'h0B);
`else
        tick();
`endif
        chk("run_done", done, 1);
        chk("run_cpu_rst", cpu_rst, 0);
        chk("run_rx_ready", rx_ready, 0);
        chk("run_mem_write", mem_write, 0);
        chk("run_error", error, 0);

        @(negedge clk);
        cpu_address = 12'h0A5; cpu_data_out = 16'hBEEF; cpu_memory_write = 1'b1;
        #1;
        chk("pass_addr", mem_address, 12'h0A5);
        chk("pass_data", mem_data, 16'hBEEF);
        chk("pass_write", mem_write, 1);
        chk("pass_read0", mem_read, 0);
        cpu_memory_write = 1'b0; cpu_memory_read = 1'b1;
        #1;
        chk("pass_read1", mem_read, 1);
        chk("pass_write0", mem_write, 0);
        rx_valid = 1'b1; rx_data = 8'h55;
        tick();
        chk("run_ignore_ready", rx_ready, 0);
        chk("run_ignore_done", done, 1);
        rx_valid = 1'b0; cpu_memory_read = 1'b0; cpu_address = '0; cpu_data_out = '0;

        // zero-length image
        do_reset();
        send(8'h00); send(8'h00);
`ifdef MU0_LOADER_CHECKSUM_EN
        chk("zero_csum_wait", done, 0);
        send(8'h00); send(8'h00);
`endif
        chk("zero_done", done, 1);
        chk("zero_cpu_rst", cpu_rst, 0);
        chk("zero_mem_write", mem_write, 0);

        // oversize image is rejected and stays rejected
        do_reset();
        send(8'h10); send(8'h01);
        chk("err_error", error, 1);
        chk("err_cpu_rst", cpu_rst, 1);
        chk("err_rx_ready", rx_ready, 0);
        chk("err_done", done, 0);
        rx_valid = 1'b1; rx_data = 8'h55;
        tick(); tick(); tick();
        chk("err_sticky", error, 1);
        chk("err_ready_sticky", rx_ready, 0);
        chk("err_no_write", mem_write, 0);
        rx_valid = 1'b0;

        // exactly full memory is accepted
        do_reset();
        send(8'h10); send(8'h00);
        chk("max_error", error, 0);
        chk("max_ready", rx_ready, 1);

        // reset mid-load, then a fresh image loads from the base
        do_reset();
        send(8'h00); send(8'h02); send(8'h12);
        do_reset();
        send(8'h00); send(8'h01); send(8'hAB); send(8'hCD);
        chk("fresh_write", mem_write, 1);
        chk("fresh_addr", mem_address, 12'h000);
        chk("fresh_data", mem_data, 16'hABCD);
`ifdef MU0_LOADER_CHECKSUM_EN
        send(8'hAB); send(8'hCD);
`else
        tick();
`endif
        chk("fresh_done", done, 1);

`ifdef MU0_LOADER_CHECKSUM_EN
        do_reset();
        send(8'h00); send(8'h02); send(8'h00); send(8'h01); send(8'h00); send(8'h02);
        send(8'h00); send(8'h03);
        chk("csum_ok_done", done, 1);
        chk("csum_ok_error", error, 0);
        do_reset();
        send(8'h00); send(8'h02); send(8'h00); send(8'h01); send(8'h00); send(8'h02);
        send(8'h00); send(8'h04);
        chk("csum_bad_error", error, 1);
        chk("csum_bad_done", done, 0);
        chk("csum_bad_cpu_rst", cpu_rst, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
